uart_rx_param: RTL
==================

Name: uart_rx_param

Overview:
- Parametrised successor to the fixed-width UART receiver on the SOMOS iCE40 serial path.
- Deserialises an asynchronous serial line using an external oversampling Tick strobe (OVS × baud).
- Supports a runtime-selectable word length, 3-sample majority voting, false-start rejection and stop-bit framing check.
- Delivers right-aligned words with a one-cycle RxDone strobe to the command decoder.

Parameters:
DATA_W, 8, maximum data bits per frame (5..16)
OVS, 16, Tick strobes per bit period (even, 8..64)
SYNC_STAGES, 2, Rx input synchroniser depth (>=2)

Ports:
Clk  input  1  system clock; all logic on rising edge
Rst_n  input  1  asynchronous active-low reset
RxEn  input  1  receiver enable; low forces IDLE
Rx  input  1  serial line, idle high, LSB first
Tick  input  1  one-Clk-wide strobe at OVS × baud
NBits  input  $clog2(DATA_W+1)  data bits per frame, sampled at start detect
RxData  output  DATA_W  received word, right-aligned, unused MSBs zero
RxDone  output  1  one-cycle pulse; RxData/FrameErr valid
FrameErr  output  1  stop bit sampled low for the last frame
Busy  output  1  high in any state other than IDLE

Behaviour:
- Reset (async assert, sync release): RxData=0, RxDone=0, FrameErr=0, Busy=0, synchroniser flops=1, state=IDLE, all counters=0.
- Rx passes through SYNC_STAGES flops; all decisions use the synchronised value rx_s.
- States: IDLE, START, DATA, STOP.
- IDLE -> START: RxEn=1 and a falling edge of rx_s (previous 1, current 0). tick_cnt=0 and bit_cnt=0 are cleared; NBits is latched into nb_q.
- nb_q clamp: NBits <5 or >DATA_W latches DATA_W.
- tick_cnt increments on each Tick and wraps at OVS-1 -> 0. Bit boundary = Tick with tick_cnt==OVS-1.
- Sampling: rx_s is sampled on the Ticks at tick_cnt = OVS/2-1, OVS/2, OVS/2+1. The bit value is the 2-of-3 majority, resolved on the OVS/2+1 Tick.
- START: majority 1 -> false start, return to IDLE with no RxDone. Majority 0 -> DATA at the bit boundary.
- DATA: the majority bit is shifted into shift_q from the MSB side (LSB first on the line). At the bit boundary bit_cnt++. bit_cnt==nb_q-1 at the boundary -> STOP.
- STOP: on stop-bit majority resolution, with no wait for the end of the bit (allows back-to-back frames):
  - RxData <= shift_q >> (DATA_W-nb_q), upper bits zero.
  - FrameErr <= ~majority.
  - RxDone=1 for exactly one Clk cycle, on the cycle after that Tick.
  - Return to IDLE.
- RxData and FrameErr hold until the next RxDone.
- A framing-error frame still delivers RxDone with data.
- A new start edge in IDLE on the cycle RxDone is high is accepted.
- RxEn low in any state: next cycle IDLE, no RxDone, RxData unchanged.
- Ticks with Tick low never advance counters. If Tick and a start edge coincide, the edge wins and the Tick is ignored.
- Rst_n assertion mid-frame aborts immediately to reset values.

Optional Feature:
- Macro UART_RX_PARITY_EN.
- Defined:
  - Adds input ParityOdd (1) and output ParityErr (1, reset 0).
  - Adds state PARITY between DATA and STOP, sampled with the same majority/boundary rules.
  - ParityErr <= (XOR of data bits ^ parity bit ^ ParityOdd) != 0, updated alongside RxDone.
- Undefined: no PARITY state, no ParityOdd/ParityErr ports, frame = start + nb_q data + stop.

Test Plan:
- Reset: OVS=16, DATA_W=8, NBits=8; send 0xA5 with a 1-stop frame -> single RxDone pulse, RxData=0x00A5, FrameErr=0, Busy low after STOP.
- Word length: NBits=5, send 0x13 then NBits=3 (clamped to 8), send 0x3C -> RxData=0x13 then 0x3C.
- Glitch: Rx low for 4 Ticks then high -> no RxDone, back to IDLE; single-Tick glitch mid-bit inside a 0x55 frame -> RxData=0x55 (majority vote).
- Framing: 0xF0 with stop bit held low -> RxDone, RxData=0xF0, FrameErr=1; next clean 0x0F -> FrameErr=0.
- Abort: RxEn dropped in bit 3 of 0x81 -> no RxDone, RxData keeps previous value; Rst_n pulsed mid-frame -> all outputs 0.
- Parity (UART_RX_PARITY_EN): ParityOdd=0, 0x07 with parity bit 1 -> ParityErr=0; parity bit 0 -> ParityErr=1; back-to-back frames with no idle gap both received.

Source files
------------

// File: rtl/uart_rx_param_if.sv
// -----------------------------------------------------------------------------
// uart_rx_param_if
//   Signal bundle between the parametrised UART receiver and its host.
//   The master side drives the serial line, the oversampling tick and the
//   frame configuration. The slave side (the receiver) returns the word,
//   its status flags and the busy indication.
//
//   Optional feature macro: UART_RX_PARITY_EN (adds ParityOdd / ParityErr).
//
//   Signals:
//     RxEn      master->slave  receiver enable; low forces IDLE
//     Rx        master->slave  serial line, idle high, LSB first
//     Tick      master->slave  one-clock strobe at OVS x baud
//     NBits     master->slave  data bits per frame, sampled at start detect
//     RxData    slave->master  received word, right-aligned
//     RxDone    slave->master  one-cycle pulse, RxData/FrameErr valid
//     FrameErr  slave->master  stop bit sampled low for the last frame
//     Busy      slave->master  receiver not idle
//     ParityOdd master->slave  odd parity select            (parity build)
//     ParityErr slave->master  parity mismatch, last frame  (parity build)
// -----------------------------------------------------------------------------
interface uart_rx_param_if #(
  parameter int DATA_W = 8
);
  localparam int NB_W = $clog2(DATA_W + 1);

  logic              RxEn;
  logic              Rx;
  logic              Tick;
  logic [NB_W-1:0]   NBits;
  logic [DATA_W-1:0] RxData;
  logic              RxDone;
  logic              FrameErr;
  logic              Busy;
`ifdef UART_RX_PARITY_EN
  logic              ParityOdd;
  logic              ParityErr;
`endif

  modport master (
    output RxEn, Rx, Tick, NBits,
`ifdef UART_RX_PARITY_EN
    output ParityOdd,
    input  ParityErr,
`endif
    input  RxData, RxDone, FrameErr, Busy
  );

  modport slave (
    input  RxEn, Rx, Tick, NBits,
`ifdef UART_RX_PARITY_EN
    input  ParityOdd,
    output ParityErr,
`endif
    output RxData, RxDone, FrameErr, Busy
  );
endinterface

// File: rtl/uart_rx_param.sv
// -----------------------------------------------------------------------------
// uart_rx_param
//   Parametrised UART receiver. Deserialises an asynchronous line using an
//   external oversampling Tick (OVS x baud), with runtime word length,
//   3-sample majority voting, false-start rejection and stop-bit framing
//   check. Delivers a right-aligned word with a one-cycle RxDone strobe.
//
//   Optional feature macro: UART_RX_PARITY_EN
//     defined   -> a parity bit follows the data bits; ParityErr reported
//     undefined -> frame is start + nb data + stop
//
//   Parameters:
//     DATA_W       maximum data bits per frame (5..16)
//     OVS          Tick strobes per bit period (even, 8..64)
//     SYNC_STAGES  Rx synchroniser depth (>=2)
//
//   Ports:
//     Clk    system clock, rising edge
//     Rst_n  asynchronous active-low reset
//     bus    uart_rx_param_if.slave (RxEn, Rx, Tick, NBits in;
//            RxData, RxDone, FrameErr, Busy out; parity signals optional)
// -----------------------------------------------------------------------------
module uart_rx_param #(
  parameter int DATA_W      = 8,
  parameter int OVS         = 16,
  parameter int SYNC_STAGES = 2
) (
  input logic            Clk,
  input logic            Rst_n,
  uart_rx_param_if.slave bus
);

  localparam int NB_W = $clog2(DATA_W + 1);
  localparam int TC_W = $clog2(OVS);

  // Sample points straddle the bit centre; the vote resolves on the last one.
  localparam logic [TC_W-1:0] TC_S0   = TC_W'(OVS / 2 - 1);
  localparam logic [TC_W-1:0] TC_S1   = TC_W'(OVS / 2);
  localparam logic [TC_W-1:0] TC_RES  = TC_W'(OVS / 2 + 1);
  localparam logic [TC_W-1:0] TC_LAST = TC_W'(OVS - 1);
  localparam logic [NB_W-1:0] NB_MIN  = NB_W'(5);
  localparam logic [NB_W-1:0] NB_MAX  = NB_W'(DATA_W);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_RX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  state_t              state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                rx_s;
  logic                rx_prev_q;
  logic [TC_W-1:0]     tick_cnt_q;
  logic [NB_W-1:0]     bit_cnt_q;
  logic [NB_W-1:0]     nb_q;
  logic [NB_W-1:0]     nb_clamped;
  logic [NB_W-1:0]     shamt;
  logic [DATA_W-1:0]   shift_q;
  logic                samp0_q, samp1_q;
  logic                maj;
  logic                par_acc_q;
  logic [DATA_W-1:0]   rx_data_q;
  logic                rx_done_q;
  logic                frame_err_q;
`ifdef UART_RX_PARITY_EN
  logic                parity_err_q;
`endif

  logic                start_edge;
  logic                tick_on;
  logic                at_res;
  logic                at_bnd;
  logic                last_bit;
  logic                start_load;
  logic                shift_en;
  logic                par_en;
  logic                frame_end;

  // ---------------------------------------------------------------------------
  // Input synchroniser and edge detector
  // ---------------------------------------------------------------------------
  // NOTE: all sequential state uses non-blocking assignments so every flop
  // samples pre-edge values and simulation matches the synthesised registers.
  // NOTE: the synchroniser and edge history reset to 1 (line idle) so that
  // reset release never looks like a start edge.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      sync_q    <= '1;
      rx_prev_q <= 1'b1;
    end else begin
      sync_q    <= {sync_q[SYNC_STAGES-2:0], bus.Rx};
      rx_prev_q <= rx_s;
    end
  end

  assign rx_s       = sync_q[SYNC_STAGES-1];
  assign start_edge = rx_prev_q & ~rx_s;

  // Ticks only advance the bit timing while a frame is in progress.
  assign tick_on  = bus.Tick && (state_q != IDLE);
  assign at_res   = tick_on && (tick_cnt_q == TC_RES);
  assign at_bnd   = tick_on && (tick_cnt_q == TC_LAST);
  assign last_bit = (bit_cnt_q == nb_q - NB_W'(1));

  // 2-of-3 vote: two earlier samples plus the line value on the resolve Tick.
  assign maj = (samp0_q & samp1_q) | (samp0_q & rx_s) | (samp1_q & rx_s);

  assign nb_clamped = (bus.NBits < NB_MIN || bus.NBits > NB_MAX) ? NB_MAX : bus.NBits;
  assign shamt      = NB_MAX - nb_q;

  // ---------------------------------------------------------------------------
  // FSM state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // ---------------------------------------------------------------------------
  // FSM next-state and control strobes
  // ---------------------------------------------------------------------------
  // NOTE: every signal written here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d    = state_q;
    start_load = 1'b0;
    shift_en   = 1'b0;
    par_en     = 1'b0;
    frame_end  = 1'b0;

    if (!bus.RxEn) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start_edge) begin
            state_d    = START;
            start_load = 1'b1;
          end
        end
        START: begin
          if (at_res && maj)  state_d = IDLE;   // false start
          else if (at_bnd)    state_d = DATA;
        end
        DATA: begin
          shift_en = at_res;
          if (at_bnd && last_bit) begin
`ifdef UART_RX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          par_en = at_res;
          if (at_bnd) state_d = STOP;
        end
`endif
        STOP: begin
          // Finish on the vote, not the bit end, so a back-to-back start
          // edge is already watched for.
          if (at_res) begin
            state_d   = IDLE;
            frame_end = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Bit timing, deserialiser and output registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      tick_cnt_q   <= '0;
      bit_cnt_q    <= '0;
      nb_q         <= NB_MAX;
      shift_q      <= '0;
      samp0_q      <= 1'b0;
      samp1_q      <= 1'b0;
      par_acc_q    <= 1'b0;
      rx_data_q    <= '0;
      rx_done_q    <= 1'b0;
      frame_err_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err_q <= 1'b0;
`endif
    end else begin
      rx_done_q <= frame_end;

      if (start_load) begin
        // A Tick coinciding with the start edge is deliberately dropped.
        tick_cnt_q <= '0;
        bit_cnt_q  <= '0;
        nb_q       <= nb_clamped;
        shift_q    <= '0;
        par_acc_q  <= 1'b0;
      end else if (tick_on) begin
        tick_cnt_q <= (tick_cnt_q == TC_LAST) ? '0 : tick_cnt_q + TC_W'(1);
        if (tick_cnt_q == TC_S0) samp0_q <= rx_s;
        if (tick_cnt_q == TC_S1) samp1_q <= rx_s;
        // LSB arrives first; entering at the MSB leaves the word top-aligned.
        if (shift_en) begin
          shift_q   <= {maj, shift_q[DATA_W-1:1]};
          par_acc_q <= par_acc_q ^ maj;
        end
        if (par_en) par_acc_q <= par_acc_q ^ maj;
        if (state_q == DATA && at_bnd)
          bit_cnt_q <= last_bit ? '0 : bit_cnt_q + NB_W'(1);
      end

      if (frame_end) begin
        rx_data_q    <= shift_q >> shamt;
        frame_err_q  <= ~maj;
`ifdef UART_RX_PARITY_EN
        parity_err_q <= par_acc_q ^ bus.ParityOdd;
`endif
      end
    end
  end

  assign bus.RxData   = rx_data_q;
  assign bus.RxDone   = rx_done_q;
  assign bus.FrameErr = frame_err_q;
  assign bus.Busy     = (state_q != IDLE);
`ifdef UART_RX_PARITY_EN
  assign bus.ParityErr = parity_err_q;
`endif

endmodule
